mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order pipeline. Sits between the EXE stage and the WB stage.
- Latches the EXE→MEM payload and waits for the data-SRAM response of any load/store issued in EXE.
- Aligns and sign/zero-extends load data, then presents the MEM→WB payload to WB with the standard valid/allowin handshake.
- Also drives a forwarding/interlock bus to ID.

Parameters:
- EXE_TO_MEM_LEN, 157, width of EXE→MEM bus.
- MEM_TO_WB_LEN, 182, width of MEM→WB bus.
- MEM_FWD_LEN, 39, width of forwarding bus to ID.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- EXE_to_MEM_valid  in  1  EXE holds a valid instruction
- MEM_allowin  out  1  MEM accepts a new instruction this cycle
- EXE_to_MEM_BUS  in  EXE_TO_MEM_LEN  {pc[31:0], gr_we, dest[4:0], alu_result[31:0], mem_req, mem_we, load_op[4:0] (one-hot {ld_b,ld_bu,ld_h,ld_hu,ld_w}), rfrom_mem, csr_num[13:0], csr_we, csr_wvalue[31:0], csr_wmask[31:0]}
- data_sram_data_ok  in  1  response for the outstanding request
- data_sram_rdata  in  32  read data, valid with data_ok
- MEM_to_WB_valid  out  1  MEM holds a finished instruction
- WB_allowin  in  1  WB accepts this cycle
- MEM_to_WB_BUS  out  MEM_TO_WB_LEN  {pc, gr_we, dest, mem_result[31:0], alu_result, rfrom_mem, csr_num, csr_we, csr_wvalue, csr_wmask}
- MEM_FWD_BUS  out  MEM_FWD_LEN  {fwd_we, dest[4:0], load_pending, fwd_result[31:0]}

Behaviour:
- Reset (async, active-high):
  - ms_valid=0, bus register=0, got_resp=0, rdata_buf=0.
  - Hence MEM_to_WB_valid=0, MEM_FWD_BUS=0, MEM_allowin=1, MEM_to_WB_BUS=0.
- Handshake:
  - ready_go = !mem_req | got_resp | data_sram_data_ok.
  - MEM_allowin = !ms_valid | (ready_go & WB_allowin).
  - MEM_to_WB_valid = ms_valid & ready_go.
  - On MEM_allowin: ms_valid <= EXE_to_MEM_valid.
  - On EXE_to_MEM_valid & MEM_allowin: bus register <= EXE_to_MEM_BUS.
  - Bus register holds its value otherwise.
- Response capture:
  - When ms_valid & mem_req & !got_resp & data_ok & !(ready_go & WB_allowin): set got_resp=1 and rdata_buf<=data_sram_rdata.
  - got_resp clears whenever MEM_allowin=1.
  - Latency: data_ok in cycle N with WB_allowin=1 → instruction reaches WB at edge N+1 (no bubble). Buffered data is used on a later cycle.
- Effective read data: rdata = got_resp ? rdata_buf : data_sram_rdata.
- Spurious data_ok (ms_valid=0, mem_req=0 or got_resp=1) is ignored and never captured.
- Load extraction, with a = alu_result[1:0]:
  - ld_b / ld_bu: byte rdata[8a+7:8a], sign- or zero-extended to 32 bits.
  - ld_h / ld_hu: halfword rdata[16a[1]+15:16a[1]], sign- or zero-extended; a[0] is ignored (alignment faults are raised upstream).
  - ld_w: rdata as is.
  - load_op=0: mem_result=0.
- Stores (mem_req & mem_we) wait for data_ok like loads. rfrom_mem=0 for stores.
- Forwarding bus:
  - fwd_we = ms_valid & gr_we.
  - load_pending = ms_valid & rfrom_mem & !ready_go; ID must stall on a match.
  - fwd_result = rfrom_mem ? mem_result : alu_result.
- WB stall: while ready_go=1 and WB_allowin=0, all outputs are held stable and got_resp stays set.
- Reset mid-transaction drops the pending response. The SRAM interface is reset in the same domain, so no late data_ok is expected.

Decomposition:
- Shared header macro.vh holds EXE_to_MEM_LEN, MEM_to_WB_LEN, MEM_FWD_LEN, DEST_LEN, and the load_op bit indices.
- One natural sub-module: load_align (combinational rdata, addr[1:0], load_op → mem_result). All sequential logic stays in mem_stage.

Test Plan:
- ld_w at addr 0x1000, data_ok 2 cycles later with rdata 0x8765_4321, WB_allowin=1:
  - MEM_to_WB_valid rises the same cycle as data_ok.
  - mem_result=0x8765_4321.
  - load_pending=1 during the 2 wait cycles.
- ld_b at addr offset 3, rdata 0x80xx_xxxx: mem_result=0xFFFF_FF80. Same with ld_bu: 0x0000_0080. ld_h offset 2, rdata 0x8001_xxxx: 0xFFFF_8001.
- data_ok with rdata 0x1234_5678 while WB_allowin=0 for 3 cycles, then SRAM rdata changes to 0xDEAD_BEEF:
  - WB receives 0x1234_5678.
  - MEM_allowin=0 until WB_allowin=1.
- Back-to-back ALU ops (mem_req=0) with EXE_to_MEM_valid=1 every cycle:
  - One instruction per cycle to WB.
  - fwd_result=alu_result.
  - load_pending=0.
- Assert reset asynchronously mid-load (before data_ok):
  - ms_valid, MEM_to_WB_valid and MEM_FWD_BUS go 0 immediately.
  - A data_ok after deassertion is ignored.
- Spurious data_ok with ms_valid=0: no state change; the next load still waits for its own data_ok.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, load_op bit positions and bus layouts for the MEM stage.
package mem_stage_pkg;
  localparam int EXE_TO_MEM_LEN = 157;
  localparam int MEM_TO_WB_LEN  = 182;
  localparam int MEM_FWD_LEN    = 39;
  localparam int DEST_LEN       = 5;

  // load_op is one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;

  typedef struct packed {
    logic [31:0]         pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         alu_result;
    logic                mem_req;
    logic                mem_we;
    logic [4:0]          load_op;
    logic                rfrom_mem;
    logic [13:0]         csr_num;
    logic                csr_we;
    logic [31:0]         csr_wvalue;
    logic [31:0]         csr_wmask;
  } exe_to_mem_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         mem_result;
    logic [31:0]         alu_result;
    logic                rfrom_mem;
    logic [13:0]         csr_num;
    logic                csr_we;
    logic [31:0]         csr_wvalue;
    logic [31:0]         csr_wmask;
  } mem_to_wb_t;

  typedef struct packed {
    logic                fwd_we;
    logic [DEST_LEN-1:0] dest;
    logic                load_pending;
    logic [31:0]         fwd_result;
  } mem_fwd_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of a 32-bit read word and extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_op,
  output logic [31:0] result
);
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    case (addr)
      2'd0:    b_sel = rdata[7:0];
      2'd1:    b_sel = rdata[15:8];
      2'd2:    b_sel = rdata[23:16];
      default: b_sel = rdata[31:24];
    endcase
    // addr[0] is ignored for halfwords; misalignment is trapped upstream
    h_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    result = '0;
    if (load_op[LD_B])       result = {{24{b_sel[7]}}, b_sel};
    else if (load_op[LD_BU]) result = {24'd0, b_sel};
    else if (load_op[LD_H])  result = {{16{h_sel[15]}}, h_sel};
    else if (load_op[LD_HU]) result = {16'd0, h_sel};
    else if (load_op[LD_W])  result = rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EXE payload until the data-SRAM answers,
// aligns load data and hands the result to WB; also feeds ID forwarding.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      EXE_to_MEM_valid,
  output logic                      MEM_allowin,
  input  logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata,
  output logic                      MEM_to_WB_valid,
  input  logic                      WB_allowin,
  output logic [MEM_TO_WB_LEN-1:0]  MEM_to_WB_BUS,
  output logic [MEM_FWD_LEN-1:0]    MEM_FWD_BUS
);
  exe_to_mem_t ms_bus;
  mem_to_wb_t  wb;
  mem_fwd_t    fwd;
  logic        ms_valid;
  logic        got_resp;
  logic [31:0] rdata_buf;
  logic [31:0] rdata;
  logic [31:0] mem_result;
  logic        ready_go;
  logic        capture;
  logic        unused_bits;

  assign ready_go        = !ms_bus.mem_req || got_resp || data_sram_data_ok;
  assign MEM_allowin     = !ms_valid || (ready_go && WB_allowin);
  assign MEM_to_WB_valid = ms_valid && ready_go;

  // Response arrives while WB is stalled: keep it for the cycle WB accepts
  assign capture = ms_valid && ms_bus.mem_req && !got_resp && data_sram_data_ok
                   && !(ready_go && WB_allowin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      ms_bus    <= '0;
      got_resp  <= 1'b0;
      rdata_buf <= '0;
    end else begin
      if (MEM_allowin) ms_valid <= EXE_to_MEM_valid;
      if (EXE_to_MEM_valid && MEM_allowin) ms_bus <= EXE_to_MEM_BUS;
      if (capture) begin
        got_resp  <= 1'b1;
        rdata_buf <= data_sram_rdata;
      end else if (MEM_allowin) begin
        got_resp  <= 1'b0;
      end
    end
  end

  assign rdata = got_resp ? rdata_buf : data_sram_rdata;

  mem_stage_load_align u_align (
    .rdata   (rdata),
    .addr    (ms_bus.alu_result[1:0]),
    .load_op (ms_bus.load_op),
    .result  (mem_result)
  );

  always_comb begin
    wb.pc         = ms_bus.pc;
    wb.gr_we      = ms_bus.gr_we;
    wb.dest       = ms_bus.dest;
    wb.mem_result = mem_result;
    wb.alu_result = ms_bus.alu_result;
    wb.rfrom_mem  = ms_bus.rfrom_mem;
    wb.csr_num    = ms_bus.csr_num;
    wb.csr_we     = ms_bus.csr_we;
    wb.csr_wvalue = ms_bus.csr_wvalue;
    wb.csr_wmask  = ms_bus.csr_wmask;

    fwd.fwd_we       = ms_valid && ms_bus.gr_we;
    fwd.dest         = ms_bus.dest;
    fwd.load_pending = ms_valid && ms_bus.rfrom_mem && !ready_go;
    fwd.fwd_result   = ms_bus.rfrom_mem ? mem_result : ms_bus.alu_result;
  end

  assign MEM_to_WB_BUS = wb;
  assign MEM_FWD_BUS   = fwd;

  // Stores need no distinct handling here; they wait on data_ok like loads
  assign unused_bits = ms_bus.mem_we;
endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage against a behavioural load/handshake model.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         EXE_to_MEM_valid = 1'b0;
  logic         MEM_allowin;
  logic [156:0] EXE_to_MEM_BUS = '0;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         MEM_to_WB_valid;
  logic         WB_allowin = 1'b1;
  logic [181:0] MEM_to_WB_BUS;
  logic [38:0]  MEM_FWD_BUS;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic        mem_req;
    logic        mem_we;
    logic [4:0]  load_op;
    logic        rfrom_mem;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
  } instr_t;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EXE_to_MEM_valid  (EXE_to_MEM_valid),
    .MEM_allowin       (MEM_allowin),
    .EXE_to_MEM_BUS    (EXE_to_MEM_BUS),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .WB_allowin        (WB_allowin),
    .MEM_to_WB_BUS     (MEM_to_WB_BUS),
    .MEM_FWD_BUS       (MEM_FWD_BUS)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkwb(input string tag, input logic [181:0] obs, input logic [181:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkfwd(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load semantics in plain arithmetic
  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a,
                                            input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a)) & 32'h0000_00FF;
    h = (rd >> (16 * (a / 2))) & 32'h0000_FFFF;
    case (op)
      5'b10000: return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      5'b01000: return b;
      5'b00100: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      5'b00010: return h;
      5'b00001: return rd;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [156:0] enc(input instr_t t);
    return {t.pc, t.gr_we, t.dest, t.alu, t.mem_req, t.mem_we, t.load_op, t.rfrom_mem,
            t.csr_num, t.csr_we, t.csr_wvalue, t.csr_wmask};
  endfunction

  function automatic logic [181:0] exp_wb(input instr_t t, input logic [31:0] mr);
    return {t.pc, t.gr_we, t.dest, mr, t.alu, t.rfrom_mem, t.csr_num, t.csr_we,
            t.csr_wvalue, t.csr_wmask};
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store
  function automatic instr_t rand_instr(input int kind);
    instr_t t;
    t.pc         = $urandom;
    t.dest       = 5'($urandom_range(0, 31));
    t.alu        = $urandom;
    t.csr_num    = 14'($urandom);
    t.csr_we     = 1'($urandom_range(0, 1));
    t.csr_wvalue = $urandom;
    t.csr_wmask  = $urandom;
    t.gr_we      = (kind == 2) ? 1'b0 : ((kind == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
    t.mem_req    = (kind != 0);
    t.mem_we     = (kind == 2);
    t.load_op    = (kind == 1) ? 5'(5'b00001 << $urandom_range(0, 4)) : 5'b00000;
    t.rfrom_mem  = (kind == 1);
    return t;
  endfunction

  task automatic garbage_bus();
    logic [159:0] g;
    g = {$urandom, $urandom, $urandom, $urandom, $urandom};
    EXE_to_MEM_BUS = g[156:0];
  endtask

  // Issue one instruction into an empty stage and walk it through to WB.
  // mr_obs is the mem_result seen on the cycle WB accepts.
  task automatic run_instr(input instr_t t, input int wait_n, input int stall_n,
                           input logic [31:0] rd, output logic [31:0] mr_obs);
    logic [31:0] mr;
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_BUS = enc(t);
    WB_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    #1;
    chk1("issue_allowin", MEM_allowin, 1'b1);
    tick();
    EXE_to_MEM_valid = 1'b0;
    garbage_bus();
    if (t.mem_req) begin
      for (int i = 0; i < wait_n; i++) begin
        data_sram_data_ok = 1'b0;
        data_sram_rdata = $urandom;
        #1;
        chk1("wait_valid", MEM_to_WB_valid, 1'b0);
        chk1("wait_allowin", MEM_allowin, 1'b0);
        chk1("wait_pending", MEM_FWD_BUS[32], t.rfrom_mem);
        chk1("wait_fwd_we", MEM_FWD_BUS[38], t.gr_we);
        tick();
      end
    end
    mr = ref_load(t.load_op, t.alu[1:0], rd);
    data_sram_data_ok = t.mem_req;
    data_sram_rdata = rd;
    WB_allowin = (stall_n == 0);
    #1;
    chk1("resp_valid", MEM_to_WB_valid, 1'b1);
    chk1("resp_allowin", MEM_allowin, WB_allowin);
    chkwb("resp_wb_bus", MEM_to_WB_BUS, exp_wb(t, mr));
    chkfwd("resp_fwd", MEM_FWD_BUS, {t.gr_we, t.dest, 1'b0, t.rfrom_mem ? mr : t.alu});
    mr_obs = MEM_to_WB_BUS[143:112];
    tick();
    for (int s = 1; s <= stall_n; s++) begin
      data_sram_data_ok = 1'($urandom_range(0, 1));
      data_sram_rdata = 32'hDEAD_BEEF;
      WB_allowin = (s == stall_n);
      #1;
      chk1("stall_valid", MEM_to_WB_valid, 1'b1);
      chk1("stall_allowin", MEM_allowin, WB_allowin);
      chkwb("stall_wb_bus", MEM_to_WB_BUS, exp_wb(t, mr));
      mr_obs = MEM_to_WB_BUS[143:112];
      tick();
    end
    data_sram_data_ok = 1'b0;
    WB_allowin = 1'b1;
    #1;
    chk1("drain_valid", MEM_to_WB_valid, 1'b0);
    chk1("drain_allowin", MEM_allowin, 1'b1);
    chk1("drain_fwd_we", MEM_FWD_BUS[38], 1'b0);
  endtask

  initial begin
    instr_t t, prev;
    logic [31:0] mr;

    // Reset state
    #1;
    chk1("rst_valid", MEM_to_WB_valid, 1'b0);
    chk1("rst_allowin", MEM_allowin, 1'b1);
    chkwb("rst_wb_bus", MEM_to_WB_BUS, '0);
    chkfwd("rst_fwd", MEM_FWD_BUS, '0);
    tick();
    tick();
    reset = 1'b0;

    // ld_w at 0x1000, response after two wait cycles
    t = rand_instr(1);
    t.load_op = 5'b00001;
    t.alu = 32'h0000_1000;
    run_instr(t, 2, 0, 32'h8765_4321, mr);
    chk32("ld_w", mr, 32'h8765_4321);

    // Byte / halfword extraction
    t = rand_instr(1);
    t.load_op = 5'b10000;
    t.alu = 32'h0000_2003;
    run_instr(t, 1, 0, 32'h8012_3456, mr);
    chk32("ld_b_off3", mr, 32'hFFFF_FF80);
    t.load_op = 5'b01000;
    run_instr(t, 0, 0, 32'h8012_3456, mr);
    chk32("ld_bu_off3", mr, 32'h0000_0080);
    t.load_op = 5'b00100;
    t.alu = 32'h0000_2002;
    run_instr(t, 1, 0, 32'h8001_1234, mr);
    chk32("ld_h_off2", mr, 32'hFFFF_8001);

    // Response during a 3-cycle WB stall; SRAM data changes afterwards
    t = rand_instr(1);
    t.load_op = 5'b00001;
    run_instr(t, 1, 3, 32'h1234_5678, mr);
    chk32("stall_hold", mr, 32'h1234_5678);

    // Store waits for data_ok too
    t = rand_instr(2);
    run_instr(t, 2, 1, $urandom, mr);
    chk32("store_result", mr, 32'd0);

    // Back-to-back ALU ops, one per cycle
    WB_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = rand_instr(0);
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_BUS = enc(t);
      #1;
      chk1("b2b_allowin", MEM_allowin, 1'b1);
      if (i > 0) begin
        chk1("b2b_valid", MEM_to_WB_valid, 1'b1);
        chkwb("b2b_wb_bus", MEM_to_WB_BUS, exp_wb(prev, 32'd0));
        chkfwd("b2b_fwd", MEM_FWD_BUS, {prev.gr_we, prev.dest, 1'b0, prev.alu});
      end
      tick();
      prev = t;
    end
    EXE_to_MEM_valid = 1'b0;
    #1;
    chk1("b2b_last_valid", MEM_to_WB_valid, 1'b1);
    chkwb("b2b_last_bus", MEM_to_WB_BUS, exp_wb(prev, 32'd0));
    tick();
    #1;
    chk1("b2b_empty", MEM_to_WB_valid, 1'b0);

    // Async reset in the middle of a pending load
    tick();
    t = rand_instr(1);
    t.gr_we = 1'b1;
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_BUS = enc(t);
    tick();
    EXE_to_MEM_valid = 1'b0;
    #1;
    chk1("pre_rst_pending", MEM_FWD_BUS[32], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_rst_valid", MEM_to_WB_valid, 1'b0);
    chkfwd("async_rst_fwd", MEM_FWD_BUS, '0);
    chkwb("async_rst_bus", MEM_to_WB_BUS, '0);
    chk1("async_rst_allowin", MEM_allowin, 1'b1);
    tick();
    reset = 1'b0;

    // Spurious data_ok while empty is ignored
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBAD0_0BAD;
    #1;
    chk1("spur_valid", MEM_to_WB_valid, 1'b0);
    chk1("spur_allowin", MEM_allowin, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
    t = rand_instr(1);
    t.load_op = 5'b00001;
    run_instr(t, 2, 0, 32'h0F0F_1234, mr);
    chk32("post_spur_load", mr, 32'h0F0F_1234);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      t = rand_instr($urandom_range(0, 2));
      run_instr(t, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
